// File: rtl/fetch_if.sv
// Bundle for the fetch stage: instruction-memory byte bus, decode handshake,
// redirect input and status outputs.
interface fetch_if #(
   parameter int ADDR_W = 7
);
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [7:0]        mem_data;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic [31:0]       instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic [ADDR_W-1:0] pc;
   logic [15:0]       fetch_count;

   modport master (
      output mem_addr, mem_rd, instr, instr_pc, instr_valid, pc, fetch_count,
      input  mem_data, redirect, redirect_pc, instr_ready
   );

   modport slave (
      input  mem_addr, mem_rd, instr, instr_pc, instr_valid, pc, fetch_count,
      output mem_data, redirect, redirect_pc, instr_ready
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch: reads four bytes per instruction from a combinational
// byte-wide memory, assembles them big-endian and presents them to decode.
module fetch_sequencer #(
   parameter int                ADDR_W   = 7,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic     clk,
   input logic     rst_n,
   fetch_if.master bus
);

   typedef enum logic {FETCH, HOLD} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [31:0]       asm_q, asm_d;
   logic [31:0]       instr_q, instr_d;
   logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
   logic              instr_valid_q, instr_valid_d;
   logic [15:0]       fetch_count_q, fetch_count_d;

   // Memory strobe is asserted during reset too, since reset lands in FETCH.
   assign bus.mem_rd      = (state_q == FETCH) || !rst_n;
   assign bus.mem_addr    = (state_q == FETCH) ? ADDR_W'(pc_q + ADDR_W'(byte_cnt_q)) : pc_q;
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.instr_valid = instr_valid_q;
   assign bus.pc          = pc_q;
   assign bus.fetch_count = fetch_count_q;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      byte_cnt_d    = byte_cnt_q;
      asm_d         = asm_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      fetch_count_d = fetch_count_q;

      if (state_q == HOLD) begin
         if (instr_valid_q && bus.instr_ready) begin
            instr_valid_d = 1'b0;
            fetch_count_d = fetch_count_q + 16'd1;
            state_d       = FETCH;
         end
      end else begin
         case (byte_cnt_q)
            2'd0: asm_d[31:24] = bus.mem_data;
            2'd1: asm_d[23:16] = bus.mem_data;
            2'd2: asm_d[15:8]  = bus.mem_data;
            default: begin
               instr_d       = {asm_q[31:8], bus.mem_data};
               instr_pc_d    = pc_q;
               instr_valid_d = 1'b1;
               pc_d          = ADDR_W'(pc_q + ADDR_W'(4));
               state_d       = HOLD;
            end
         endcase
         byte_cnt_d = byte_cnt_q + 2'd1;
      end

      // Redirect overrides fetch progress but lets a same-edge handshake count.
      if (bus.redirect) begin
         pc_d          = bus.redirect_pc & ~ADDR_W'(3);
         byte_cnt_d    = 2'd0;
         state_d       = FETCH;
         instr_valid_d = 1'b0;
         instr_d       = instr_q;
         instr_pc_d    = instr_pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= FETCH;
         pc_q          <= RESET_PC;
         byte_cnt_q    <= 2'd0;
         asm_q         <= '0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         byte_cnt_q    <= byte_cnt_d;
         asm_q         <= asm_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         fetch_count_q <= fetch_count_d;
      end
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controls the instruction-fetch stage. Owns the PC and drives a byte-wide, combinational-read instruction memory, issuing four byte reads per instruction. It assembles each instruction big-endian (byte at PC is bits 31:24) and hands it to decode over a valid/ready handshake. It accepts branch/jump redirects from later stages and replaces the free-running PC+4 counter in the fetch path.

Parameters:
ADDR_W, 7, byte-address width of instruction memory (128 bytes); all PC arithmetic is modulo 2^ADDR_W.
RESET_PC, 0, PC value loaded on reset; low 2 bits must be 0.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  synchronous active-low reset.
mem_addr  out  ADDR_W  byte address to instruction memory.
mem_rd  out  1  read strobe; high while a byte is being fetched.
mem_data  in  8  byte at mem_addr; valid in the same cycle (combinational read).
redirect  in  1  branch/jump taken; sampled each rising edge.
redirect_pc  in  ADDR_W  new PC target; bits [1:0] are ignored (forced to 0).
instr  out  32  assembled instruction.
instr_pc  out  ADDR_W  PC of instr.
instr_valid  out  1  instr/instr_pc are valid.
instr_ready  in  1  decode accepts instr.
pc  out  ADDR_W  current fetch PC (registered).
fetch_count  out  16  number of instructions accepted by decode; wraps at 2^16.

Behaviour:
- Reset (rst_n low at an edge), regardless of state or of redirect:
  - pc=RESET_PC; state=FETCH; byte_cnt=0; assembly register=0.
  - instr=0; instr_pc=0; instr_valid=0; fetch_count=0.
- mem_rd and mem_addr are combinational from state:
  - In FETCH: mem_rd=1 (also during a reset cycle), mem_addr=(pc+byte_cnt) mod 2^ADDR_W.
  - In HOLD: mem_rd=0, mem_addr=pc.
- State FETCH, byte_cnt k=0..2, no redirect: write mem_data into assembly bits [31-8k:24-8k]; byte_cnt<=k+1.
- State FETCH, k=3, no redirect:
  - instr<={assembly[31:8], mem_data}; instr_pc<=pc; instr_valid<=1.
  - pc<=pc+4 (wraps); byte_cnt<=0; state<=HOLD.
- Latency: instr_valid rises after the 4th FETCH edge; first instruction is valid 4 cycles after reset release.
- State HOLD:
  - instr, instr_pc and instr_valid hold stable while instr_ready=0.
  - On an edge with instr_valid&&instr_ready: instr_valid<=0; fetch_count<=fetch_count+1; state<=FETCH.
  - Steady throughput is one instruction per 5 cycles.
- redirect=1 at an edge (any state, reset not asserted) has priority over fetch progress:
  - pc<=redirect_pc with bits [1:0]=0; byte_cnt<=0; state<=FETCH; instr_valid<=0.
  - Partially assembled bytes are discarded; no instruction from the old path is presented.
- redirect coinciding with instr_valid&&instr_ready: the handshake completes (fetch_count increments), then the redirect applies.
- redirect during FETCH k=3: the completing instruction is dropped (instr_valid stays 0, instr unchanged).
- Back-to-back redirects: the last one wins, and each restarts the 4-byte sequence.
- Wrap-around:
  - pc at 2^ADDR_W-4 fetches bytes 124..127 (default ADDR_W); next pc=0.
  - byte addresses never exceed 2^ADDR_W-1.
- instr_ready while instr_valid=0 has no effect.
- No combinational path from instr_ready or redirect to any output.

Test Plan:
- Reset/first fetch: mem[0..3]=8C,01,00,04; release rst_n, hold instr_ready=1 -> mem_addr 0,1,2,3 on successive cycles; then instr=0x8C010004, instr_pc=0, instr_valid=1; next edge fetch_count=1, pc=4.
- Backpressure: mem[4..7]=AC,22,00,08, instr_ready=0 for 6 cycles after valid -> instr stays 0xAC220008, instr_pc=4, mem_rd=0; raise ready -> valid drops after one edge, fetch resumes at mem_addr 8.
- Redirect mid-fetch: assert redirect with redirect_pc=0x13 when byte_cnt=2 -> next mem_addr=0x10; assembled instr is mem[0x10..0x13]; instr_pc=0x10; no instruction from the old PC appears.
- Redirect with handshake: instr_valid=1, instr_ready=1, redirect=1 with redirect_pc=0x40 on the same edge -> fetch_count increments, instr_valid=0, pc=0x40.
- Wrap: redirect to 0x7C, mem[7C..7F]=00,00,00,0C -> instr=0x0000000C, instr_pc=0x7C; after handshake mem_addr=0, pc=0.
- Reset mid-HOLD: instr_valid=1, rst_n=0 for one edge (redirect also 1) -> instr_valid=0, instr=0, fetch_count=0, pc=RESET_PC; fetch restarts at address 0.
